// File: rtl/quad_scan_ctrl.sv
// quad_scan_ctrl: one quadrature-decode datapath shared by NUM_CH rotary
// encoders. Each scan tick walks every channel through LOAD/DECODE/WRITE.
// Per-channel prior {B,A}, position count and sticky error live in arrays
// and are served through a one-cycle request/acknowledge read port.
// Optional build macro QUAD_SCAN_SAT_EN: counts saturate at 0 and all-ones
// instead of wrapping modulo 2^CNT_W.
module quad_scan_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int SCAN_DIV = 32
) (
    input  logic                      hwclk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic                      rd_req,
    input  logic [$clog2(NUM_CH)-1:0] rd_ch,
    output logic                      rd_ack,
    output logic [CNT_W-1:0]          rd_cnt,
    output logic                      rd_err,
    output logic                      scan_busy
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int TK_W = $clog2(SCAN_DIV);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [TK_W-1:0] TICK_MAX = TK_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {S_PRIME, S_WAIT, S_LOAD, S_DECODE, S_WRITE} state_t;

    state_t            state;
    logic [CH_W-1:0]   idx;
    logic [1:0]        prime_dly;
    logic [TK_W-1:0]   tick_cnt;
    logic              tick;

    logic [NUM_CH-1:0] a_meta, a_sync, b_meta, b_sync;

    logic [1:0]        prior_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic              err_q   [NUM_CH];

    // Shared datapath registers for the channel currently being scanned
    logic [1:0]        ld_old, ld_new;
    logic [CNT_W-1:0]  ld_cnt;
    logic              dec_inc, dec_dn, dec_err;

    logic [1:0]        step;
    logic [CNT_W-1:0]  cnt_next;
    logic              rd_ch_ok;

    // Position of a {B,A} code along the forward rotation 00,10,11,01
    function automatic logic [1:0] phase(input logic [1:0] ba);
        case (ba)
            2'b00:   phase = 2'd0;
            2'b10:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    // Phase difference mod 4: 1 = forward, 3 = backward, 2 = skipped state
    assign step = phase(ld_new) - phase(ld_old);

    assign tick     = (tick_cnt == TICK_MAX);
    assign rd_ch_ok = (32'(rd_ch) < NUM_CH);

    // Next count for the channel in WRITE, wrapping or saturating
    always_comb begin
        cnt_next = ld_cnt;
`ifdef QUAD_SCAN_SAT_EN
        if (dec_inc && (ld_cnt != '1))
            cnt_next = ld_cnt + CNT_W'(1);
        else if (dec_dn && (ld_cnt != '0))
            cnt_next = ld_cnt - CNT_W'(1);
`else
        if (dec_inc)
            cnt_next = ld_cnt + CNT_W'(1);
        else if (dec_dn)
            cnt_next = ld_cnt - CNT_W'(1);
`endif
    end

    // Two-flop synchroniser on every encoder input bit
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            a_meta <= '0;
            a_sync <= '0;
            b_meta <= '0;
            b_sync <= '0;
        end else begin
            a_meta <= enc_a;
            a_sync <= a_meta;
            b_meta <= enc_b;
            b_sync <= b_meta;
        end
    end

    // Free-running scan tick divider
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else
            tick_cnt <= tick ? '0 : tick_cnt + TK_W'(1);
    end

    // Scan FSM, channel arrays and read port; the read-side error clear is
    // written before the WRITE-side set so a simultaneous set wins.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state     <= S_PRIME;
            idx       <= '0;
            prime_dly <= '0;
            scan_busy <= 1'b1;
            ld_old    <= '0;
            ld_new    <= '0;
            ld_cnt    <= '0;
            dec_inc   <= 1'b0;
            dec_dn    <= 1'b0;
            dec_err   <= 1'b0;
            rd_ack    <= 1'b0;
            rd_cnt    <= '0;
            rd_err    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                prior_q[i] <= 2'b00;
                cnt_q[i]   <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            rd_ack <= rd_req;
            if (rd_req && rd_ch_ok) begin
                rd_cnt        <= cnt_q[rd_ch];
                rd_err        <= err_q[rd_ch];
                err_q[rd_ch]  <= 1'b0;
            end else begin
                rd_cnt <= '0;
                rd_err <= 1'b0;
            end

            case (state)
                S_PRIME: begin
                    // First two cycles let the synchroniser fill
                    if (prime_dly != 2'd2) begin
                        prime_dly <= prime_dly + 2'd1;
                    end else begin
                        prior_q[idx] <= {b_sync[idx], a_sync[idx]};
                        if (idx == LAST_CH) begin
                            idx       <= '0;
                            state     <= S_WAIT;
                            scan_busy <= 1'b0;
                        end else begin
                            idx <= idx + CH_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        idx       <= '0;
                        state     <= S_LOAD;
                        scan_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    ld_old <= prior_q[idx];
                    ld_new <= {b_sync[idx], a_sync[idx]};
                    ld_cnt <= cnt_q[idx];
                    state  <= S_DECODE;
                end
                S_DECODE: begin
                    dec_inc <= (step == 2'd1);
                    dec_dn  <= (step == 2'd3);
                    dec_err <= (step == 2'd2);
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    prior_q[idx] <= ld_new;
                    if (dec_err)
                        err_q[idx] <= 1'b1;
                    else
                        cnt_q[idx] <= cnt_next;
                    if (idx == LAST_CH) begin
                        idx       <= '0;
                        state     <= S_WAIT;
                        scan_busy <= 1'b0;
                    end else begin
                        idx   <= idx + CH_W'(1);
                        state <= S_LOAD;
                    end
                end
                default: begin
                    state     <= S_PRIME;
                    scan_busy <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_quad_scan_ctrl.sv
// tb_quad_scan_ctrl: directed and randomized checks of quad_scan_ctrl against
// a rotation-position model of each encoder. Inputs change only right after
// a scan completes, so every scan sees one settled input step.
module tb_quad_scan_ctrl;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 16;
    localparam int SCAN_DIV = 32;
    localparam int unsigned MAXV = (1 << CNT_W) - 1;

    logic              hwclk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] enc_a = '0;
    logic [NUM_CH-1:0] enc_b = '0;
    logic              rd_req = 1'b0;
    logic [1:0]        rd_ch = '0;
    logic              rd_ack;
    logic [CNT_W-1:0]  rd_cnt;
    logic              rd_err;
    logic              scan_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per-channel count, sticky error and last seen {B,A}
    int unsigned m_cnt   [NUM_CH];
    bit          m_err   [NUM_CH];
    logic [1:0]  m_prior [NUM_CH];
    logic [1:0]  seq     [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #5 hwclk = ~hwclk;

    quad_scan_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SCAN_DIV(SCAN_DIV)) dut (
        .hwclk(hwclk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack), .rd_cnt(rd_cnt),
        .rd_err(rd_err), .scan_busy(scan_busy)
    );

    function automatic int ring_pos(input logic [1:0] ba);
        for (int i = 0; i < 4; i++)
            if (seq[i] == ba) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c]   = 0;
            m_err[c]   = 0;
            m_prior[c] = {enc_b[c], enc_a[c]};
        end
    endtask

    task automatic model_scan();
        for (int c = 0; c < NUM_CH; c++) begin
            logic [1:0] nb;
            int d;
            nb = {enc_b[c], enc_a[c]};
            d  = (ring_pos(nb) - ring_pos(m_prior[c]) + 4) % 4;
            if (d == 2) m_err[c] = 1;
`ifdef QUAD_SCAN_SAT_EN
            else if (d == 1 && m_cnt[c] < MAXV) m_cnt[c] = m_cnt[c] + 1;
            else if (d == 3 && m_cnt[c] > 0)    m_cnt[c] = m_cnt[c] - 1;
`else
            else if (d == 1) m_cnt[c] = (m_cnt[c] + 1) & MAXV;
            else if (d == 3) m_cnt[c] = (m_cnt[c] + MAXV) & MAXV;
`endif
            m_prior[c] = nb;
        end
    endtask

    task automatic wait_busy(input logic level);
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            @(negedge hwclk);
            if (scan_busy === level) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL scan_busy_timeout: scan_busy stuck, wanted %0b", level);
    endtask

    task automatic wait_scan_done();
        wait_busy(1'b1);
        wait_busy(1'b0);
    endtask

    task automatic step_to(input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] b);
        wait_scan_done();
        enc_a = a;
        enc_b = b;
        wait_scan_done();
        model_scan();
    endtask

    task automatic step_ch(input int c, input logic [1:0] ba);
        logic [NUM_CH-1:0] a, b;
        a = enc_a;
        b = enc_b;
        a[c] = ba[0];
        b[c] = ba[1];
        step_to(a, b);
    endtask

    task automatic read_ch(input int c, output logic ack, output logic [CNT_W-1:0] v,
                           output logic e);
        @(negedge hwclk);
        rd_req = 1'b1;
        rd_ch  = c[1:0];
        @(negedge hwclk);
        rd_req = 1'b0;
        ack = rd_ack;
        v   = rd_cnt;
        e   = rd_err;
        m_err[c] = 0;
    endtask

    task automatic hold_reset(input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] b);
        @(negedge hwclk);
        reset  = 1'b1;
        rd_req = 1'b0;
        enc_a  = a;
        enc_b  = b;
        repeat (3) @(negedge hwclk);
    endtask

    task automatic release_reset(output int n);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge hwclk);
            n++;
            if (scan_busy === 1'b0) break;
        end
        model_reset();
    endtask

    task automatic test_reset();
        int n;
        logic ack, e;
        logic [CNT_W-1:0] v;
        hold_reset(4'b0101, 4'b0011);
        n_cmp++;
        if (scan_busy !== 1'b1 || rd_ack !== 1'b0 || rd_cnt !== '0 || rd_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%0b ack=%0b cnt=%0d err=%0b, want 1 0 0 0",
                     scan_busy, rd_ack, rd_cnt, rd_err);
        end
        release_reset(n);
        n_cmp++;
        if (n != NUM_CH + 2) begin
            n_bad++;
            $display("FAIL prime_len: got %0d cycles, want %0d", n, NUM_CH + 2);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            read_ch(c, ack, v, e);
            n_cmp++;
            if (ack !== 1'b1 || v !== '0 || e !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_read ch%0d: got ack=%0b cnt=%0d err=%0b, want 1 0 0",
                         c, ack, v, e);
            end
        end
    endtask

    task automatic test_forward();
        int n;
        logic ack, e;
        logic [CNT_W-1:0] v;
        hold_reset('0, '0);
        release_reset(n);
        step_ch(1, 2'b10); step_ch(1, 2'b11); step_ch(1, 2'b01); step_ch(1, 2'b00);
        read_ch(1, ack, v, e);
        n_cmp++;
        if (ack !== 1'b1 || v !== CNT_W'(4) || e !== 1'b0) begin
            n_bad++;
            $display("FAIL fwd_ch1: got ack=%0b cnt=%0d err=%0b, want 1 4 0", ack, v, e);
        end
        step_ch(1, 2'b01); step_ch(1, 2'b11); step_ch(1, 2'b10); step_ch(1, 2'b00);
        read_ch(1, ack, v, e);
        n_cmp++;
        if (ack !== 1'b1 || v !== '0 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL rev_ch1: got ack=%0b cnt=%0d err=%0b, want 1 0 0", ack, v, e);
        end
    endtask

    task automatic test_wrap();
        logic ack, e;
        logic [CNT_W-1:0] v, want;
`ifdef QUAD_SCAN_SAT_EN
        want = '0;
`else
        want = '1;
`endif
        step_ch(2, 2'b01);
        read_ch(2, ack, v, e);
        n_cmp++;
        if (ack !== 1'b1 || v !== want || e !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_down: got ack=%0b cnt=%0h err=%0b, want 1 %0h 0", ack, v, e, want);
        end
        step_ch(2, 2'b00);
        want = CNT_W'(m_cnt[2]);
        read_ch(2, ack, v, e);
        n_cmp++;
        if (v !== want || e !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_up: got cnt=%0h err=%0b, want %0h 0", v, e, want);
        end
    endtask

    task automatic test_error();
        logic ack, e;
        logic [CNT_W-1:0] v;
        step_ch(3, 2'b11);
        read_ch(3, ack, v, e);
        n_cmp++;
        if (ack !== 1'b1 || v !== '0 || e !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got ack=%0b cnt=%0d err=%0b, want 1 0 1", ack, v, e);
        end
        read_ch(3, ack, v, e);
        n_cmp++;
        if (ack !== 1'b1 || v !== '0 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got ack=%0b cnt=%0d err=%0b, want 1 0 0", ack, v, e);
        end
        step_ch(3, 2'b00);
        read_ch(3, ack, v, e);
        n_cmp++;
        if (e !== 1'b1 || v !== '0) begin
            n_bad++;
            $display("FAIL err_back: got cnt=%0d err=%0b, want 0 1", v, e);
        end
    endtask

    task automatic test_same_cycle();
        logic ack, e;
        logic [CNT_W-1:0] v;
        step_ch(0, 2'b10); step_ch(0, 2'b11); step_ch(0, 2'b01);
        step_ch(0, 2'b00); step_ch(0, 2'b10);
        read_ch(0, ack, v, e);
        n_cmp++;
        if (v !== CNT_W'(5)) begin
            n_bad++;
            $display("FAIL same_pre: got cnt=%0d, want 5", v);
        end
        // Read ch0 on the very edge its WRITE lands (+1 from 5)
        wait_scan_done();
        enc_b[0] = 1'b1;
        enc_a[0] = 1'b1;
        wait_busy(1'b1);
        repeat (2) @(negedge hwclk);
        rd_req = 1'b1;
        rd_ch  = 2'd0;
        @(negedge hwclk);
        rd_req = 1'b0;
        n_cmp++;
        if (rd_ack !== 1'b1 || rd_cnt !== CNT_W'(5)) begin
            n_bad++;
            $display("FAIL same_write_cnt: got ack=%0b cnt=%0d, want 1 5", rd_ack, rd_cnt);
        end
        @(negedge hwclk);
        n_cmp++;
        if (rd_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_pulse: got ack=%0b one cycle later, want 0", rd_ack);
        end
        wait_busy(1'b0);
        model_scan();
        read_ch(0, ack, v, e);
        n_cmp++;
        if (v !== CNT_W'(6) || v !== CNT_W'(m_cnt[0])) begin
            n_bad++;
            $display("FAIL same_post: got cnt=%0d, want 6", v);
        end
        // Read ch3 on the edge its WRITE sets the error: old value out, set wins
        wait_scan_done();
        enc_b[3] = ~m_prior[3][1];
        enc_a[3] = ~m_prior[3][0];
        wait_busy(1'b1);
        repeat (11) @(negedge hwclk);
        rd_req = 1'b1;
        rd_ch  = 2'd3;
        @(negedge hwclk);
        rd_req = 1'b0;
        n_cmp++;
        if (rd_ack !== 1'b1 || rd_err !== 1'b0) begin
            n_bad++;
            $display("FAIL same_write_err: got ack=%0b err=%0b, want 1 0", rd_ack, rd_err);
        end
        wait_busy(1'b0);
        model_scan();
        read_ch(3, ack, v, e);
        n_cmp++;
        if (e !== 1'b1) begin
            n_bad++;
            $display("FAIL set_wins: got err=%0b, want 1", e);
        end
    endtask

    task automatic test_random();
        logic ack, e;
        logic [CNT_W-1:0] v;
        logic [NUM_CH-1:0] a, b;
        for (int it = 0; it < 24; it++) begin
            int c, r, p;
            bit want_e;
            logic [CNT_W-1:0] want_v;
            a = enc_a;
            b = enc_b;
            for (int k = 0; k < NUM_CH; k++) begin
                r = $urandom_range(0, 9);
                p = ring_pos(m_prior[k]);
                if (r >= 3 && r <= 5) p = (p + 1) % 4;
                else if (r >= 6 && r <= 8) p = (p + 3) % 4;
                else if (r == 9) p = (p + 2) % 4;
                a[k] = seq[p][0];
                b[k] = seq[p][1];
            end
            step_to(a, b);
            c = $urandom_range(0, NUM_CH - 1);
            want_v = CNT_W'(m_cnt[c]);
            want_e = m_err[c];
            read_ch(c, ack, v, e);
            n_cmp++;
            if (ack !== 1'b1 || v !== want_v || e !== want_e) begin
                n_bad++;
                $display("FAIL rand[%0d] ch%0d: got ack=%0b cnt=%0d err=%0b, want 1 %0d %0b",
                         it, c, ack, v, e, want_v, want_e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] w0, w1;
        w0 = CNT_W'(m_cnt[0]);
        w1 = CNT_W'(m_cnt[1]);
        @(negedge hwclk);
        rd_req = 1'b1;
        rd_ch  = 2'd0;
        @(negedge hwclk);
        rd_ch  = 2'd1;
        n_cmp++;
        if (rd_ack !== 1'b1 || rd_cnt !== w0) begin
            n_bad++;
            $display("FAIL b2b_first: got ack=%0b cnt=%0d, want 1 %0d", rd_ack, rd_cnt, w0);
        end
        @(negedge hwclk);
        rd_req = 1'b0;
        n_cmp++;
        if (rd_ack !== 1'b1 || rd_cnt !== w1) begin
            n_bad++;
            $display("FAIL b2b_second: got ack=%0b cnt=%0d, want 1 %0d", rd_ack, rd_cnt, w1);
        end
        m_err[0] = 0;
        m_err[1] = 0;
        @(negedge hwclk);
        n_cmp++;
        if (rd_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: got ack=%0b, want 0", rd_ack);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic ack, e;
        logic [CNT_W-1:0] v;
        step_ch(2, seq[(ring_pos(m_prior[2]) + 1) % 4]);
        wait_scan_done();
        enc_b[2] = seq[(ring_pos(m_prior[2]) + 1) % 4][1];
        enc_a[2] = seq[(ring_pos(m_prior[2]) + 1) % 4][0];
        wait_busy(1'b1);
        repeat (7) @(negedge hwclk);
        reset = 1'b1;
        @(negedge hwclk);
        n_cmp++;
        if (scan_busy !== 1'b1 || rd_ack !== 1'b0 || rd_cnt !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got busy=%0b ack=%0b cnt=%0d, want 1 0 0",
                     scan_busy, rd_ack, rd_cnt);
        end
        repeat (2) @(negedge hwclk);
        release_reset(n);
        n_cmp++;
        if (n != NUM_CH + 2) begin
            n_bad++;
            $display("FAIL reprime_len: got %0d cycles, want %0d", n, NUM_CH + 2);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            read_ch(c, ack, v, e);
            n_cmp++;
            if (ack !== 1'b1 || v !== '0 || e !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset_read ch%0d: got ack=%0b cnt=%0d err=%0b, want 1 0 0",
                         c, ack, v, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_wrap();
        test_error();
        test_same_cycle();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/quad_scan_ctrl.md
Name: quad_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one quadrature-decode datapath among NUM_CH rotary encoders. The block performs these steps:
- Synchronises all A/B inputs.
- Sequences a PRIME / WAIT / LOAD / DECODE / WRITE state machine once per scan tick.
- Keeps per-channel prior state, position count and sticky error in register arrays.
- Serves a request/acknowledge read port to downstream logic (LED drivers, UART reporter).

Parameters:
NUM_CH, 4, number of encoder channels (2..8)
CNT_W, 16, position counter width per channel
SCAN_DIV, 32, hwclk cycles between scan ticks; must be >= 3*NUM_CH+2

Ports:
hwclk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enc_a  input  NUM_CH  encoder A inputs, asynchronous
enc_b  input  NUM_CH  encoder B inputs, asynchronous
rd_req  input  1  read request, single-cycle pulse
rd_ch  input  $clog2(NUM_CH)  channel to read, sampled with rd_req
rd_ack  output  1  read acknowledge, one-cycle pulse
rd_cnt  output  CNT_W  count of requested channel, valid with rd_ack
rd_err  output  1  sticky error of requested channel, valid with rd_ack
scan_busy  output  1  high while the FSM is not in WAIT

Behaviour:
- Reset is hwclk-domain reset: reset, asynchronous, active-high; clock hwclk. Reset values:
  - state=PRIME, channel index=0, tick counter=0.
  - All counts=0, errors=0, prior states=2'b00.
  - rd_ack=0, rd_cnt=0, rd_err=0, scan_busy=1.
- Synchroniser: 2-FF per input bit. Decode uses synchronised {B,A}.
- PRIME (after reset):
  - One clock per channel: copies the synchronised {B,A} into prior state; no count change.
  - After channel NUM_CH-1 → WAIT.
  - PRIME begins 2 cycles after reset release so the synchroniser is filled. The delay cycles count toward the NUM_CH+2 total.
- Tick counter: free-running 0..SCAN_DIV-1. The tick occurs on wrap to 0.
- WAIT: scan_busy=0. On tick → LOAD with index=0.
- LOAD: registers the channel's prior state, new synchronised {B,A}, and count.
- DECODE: computes delta from {old BA, new BA}:
  - +1: 00→10, 10→11, 11→01, 01→00.
  - -1: the reverse of each +1 transition.
  - 0: no change.
  - error: both bits change (00↔11, 01↔10).
- WRITE:
  - count += delta, modulo 2^CNT_W; wraps 0→max on -1 and max→0 on +1.
  - prior state ← new BA, including on error.
  - error → that channel's sticky error set; count unchanged.
  - If index==NUM_CH-1 → WAIT, else index+1 → LOAD.
- Scan duration is 3*NUM_CH cycles and always completes before the next tick, given the SCAN_DIV constraint.
- Read port:
  - rd_req accepted in every state, including PRIME.
  - rd_ack pulses exactly one cycle after rd_req, with the registered count and error.
  - The error read clears that channel's sticky error. If a WRITE to the same channel sets the error in the same cycle as rd_req, set wins (error stays 1) and rd_err returns the pre-update value.
  - Count read in the same cycle as a WRITE to that channel returns the pre-update count.
  - rd_req while rd_ack is high is accepted normally, giving back-to-back acks.
  - rd_ch >= NUM_CH: rd_ack pulses, rd_cnt=0, rd_err=0, no state change.
- Reset mid-scan aborts immediately. All state returns to reset values and PRIME reruns.

Optional Feature:
QUAD_SCAN_SAT_EN
- Defined: counts saturate at 0 and 2^CNT_W-1 (held, no wrap). Saturation does not set the error.
- Undefined: modulo wrap as described in Behaviour.

Test Plan:
- Reset release with enc_a=4'b0101, enc_b=4'b0011 → after PRIME, scan_busy=0. Read of ch0..3 gives cnt=0, err=0 (no spurious counts).
- Ch1 BA sequence 00→10→11→01→00, one step per tick → read ch1: cnt=4, err=0. Reverse sequence afterwards → cnt=0.
- Ch2 at count 0, one -1 step → cnt=16'hFFFF (with QUAD_SCAN_SAT_EN: cnt=0).
- Ch3 BA 00→11 in one tick → first read err=1 with cnt unchanged; second read err=0.
- rd_req on ch0 in the same cycle as ch0 WRITE with +1 from cnt=5 → rd_cnt=5, rd_ack one cycle later; next read → 6.
- Assert reset during DECODE of ch2 with nonzero counts → all counts 0, scan_busy=1. Re-PRIME completes in NUM_CH+2 cycles.
